clk_edge_rx: RTL and testbench
==============================

Name: clk_edge_rx

Overview:
Receiving end of the divided-clock path. Takes a slow clock or strobe (a divided clock such as clk_out/clk_m, or an off-board EPP strobe), asynchronous to clk_in. Synchronises it and emits one-cycle rise/fall enables for clk_in-domain logic. Measures the input period in clk_in cycles and flags lock when the period is stable, or timeout when the input stops toggling.

Parameters:
CNT_W, 16, width of period counter and period output
TOL, 1, max |period - reference| (cycles) counted as a match
LOCK_N, 4, consecutive matching periods required to assert locked

Ports:
clk_in  input  1  system clock, all logic on posedge
rst  input  1  asynchronous reset, active-high
sig_in  input  1  asynchronous slow clock/strobe to receive
rise_p  output  1  one-cycle pulse per synchronised rising edge of sig_in
fall_p  output  1  one-cycle pulse per synchronised falling edge of sig_in
period  output  CNT_W  last measured rise-to-rise interval, clk_in cycles
period_vld  output  1  one-cycle pulse when period updates
locked  output  1  period stable within TOL for LOCK_N consecutive periods
timeout  output  1  sticky: counter saturated with no rising edge; cleared by next rise_p

Behaviour:
- Reset (async, rst=1): all outputs 0; synchroniser flops 0; counter 0; state IDLE; reference 0; match count 0.
- Synchroniser: s1<=sig_in, s2<=s1, s3<=s2.
- rise_p <= s2&~s3 and fall_p <= ~s2&s3, both registered.
- Latency: rise_p/fall_p assert on the 3rd clk_in edge after sig_in changes (setup met); width exactly 1 cycle.
- Pulses < 2 clk_in cycles wide may be lost; this is not detected.
- Period counter cnt (CNT_W bits):
  - On each internal rise (s2&~s3): cnt<=1.
  - Otherwise cnt increments, saturating at 2^CNT_W-1.
- Measurement: on internal rise with state != IDLE: period<=cnt and period_vld=1 in the same cycle as rise_p.
- Saturation: when cnt reaches 2^CNT_W-1 with no rise that cycle: timeout<=1, locked<=0, state->IDLE.
- Rise and saturation in the same cycle: the rise wins. period is the max value, timeout is not set.
- Lock FSM, evaluated on each internal rise; match = |cnt - ref| <= TOL, unsigned compare via larger-minus-smaller:
  - IDLE: ->MEAS. The first edge only starts the count; no period_vld. timeout cleared here.
  - MEAS: ref<=cnt, mcnt<=0, ->TRACK.
  - TRACK, match: mcnt++; when mcnt reaches LOCK_N-1 (i.e. this is the LOCK_N-th match), ->LOCKED and locked<=1 the next cycle.
  - TRACK, mismatch: ref<=cnt, mcnt<=0.
  - LOCKED, match: stay; ref unchanged (no drift tracking).
  - LOCKED, mismatch: locked<=0, ref<=cnt, mcnt<=0, ->TRACK.
  - Any state, saturation: ->IDLE.
- rst mid-operation: immediate return to reset values. The first rise after release is treated as an IDLE edge.
- fall_p does not affect the FSM.

Optional Feature:
DUTY_MEAS_EN.
- Defined: adds outputs high_time (CNT_W) and high_vld (1).
  - A second counter restarts at 1 on internal rise and is captured into high_time on the next internal fall.
  - high_vld pulses with fall_p when the state is not IDLE.
  - Saturates like cnt.
  - Reset value 0.
- Undefined: these ports and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package clk_rx_pkg:
  - state encoding IDLE/MEAS/TRACK/LOCKED (2-bit)
  - default CNT_W, TOL and LOCK_N constants
- Sub-module sync_edge: 2-flop synchroniser plus edge-detect register, outputs the internal rise/fall. Reusable for EPP strobes.

Test Plan:
- rst=1 then released, sig_in=0 held -> all outputs 0; with CNT_W=8, timeout rises after 255 cycles with no rise; locked=0.
- sig_in toggled every 2 clk_in cycles (period 4) -> rise_p/fall_p single-cycle 3 edges after each transition. First period_vld at the 2nd rise with period=4. locked=1 one cycle after the 6th rise_p (LOCK_N=4).
- Locked at period 4, then one period of 7 -> period=7, locked drops the cycle after that rise. Four further 7-cycle periods -> locked reasserts.
- Periods 4,5,4,3,4,5 with TOL=1 -> all count as matches against ref=4; locked asserted. A period of 6 -> unlocked.
- rst pulsed for 1 cycle while LOCKED -> outputs 0 immediately. The next rise gives no period_vld; the following rise gives period_vld.
- With DUTY_MEAS_EN, sig_in high 3 / low 5 cycles -> high_time=3 with high_vld on each fall_p; period=8.

Source files
------------

// File: rtl/clk_rx_pkg.sv
// Shared types and default parameters for the divided-clock receiver.
// Holds the lock FSM state encoding and the default counter/lock settings.
package clk_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEAS   = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } rx_state_e;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_TOL    = 1;
  localparam int DEF_LOCK_N = 4;

endpackage

// File: rtl/clk_edge_rx_sync.sv
// Two-flop synchroniser plus an edge-detect flop for a slow asynchronous input.
// o_rise/o_fall are combinational off the registered stages, one cycle wide.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/clk_edge_rx.sv
// Receiver for a slow clock/strobe: edge pulses, rise-to-rise period, lock and timeout.
// Define DUTY_MEAS_EN to add high-time measurement (high_time/high_vld).
module clk_edge_rx
  import clk_rx_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TOL    = DEF_TOL,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic             rise_p,
  output logic             fall_p,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
`ifdef DUTY_MEAS_EN
  output logic [CNT_W-1:0] high_time,
  output logic             high_vld,
`endif
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  localparam int               MC_W    = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  MC_LAST = MC_W'(LOCK_N - 1);
  localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

  logic             w_rise;
  logic             w_fall;
  logic             w_sat;
  logic             w_match;
  logic [CNT_W-1:0] w_diff;

  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ref;
  logic [MC_W-1:0]  r_mcnt;

  sync_edge u_sync (
    .clk    (clk_in),
    .rst    (rst),
    .i_sig  (sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Larger-minus-smaller keeps the tolerance compare unsigned.
  assign w_diff    = (r_cnt >= r_ref) ? (r_cnt - r_ref) : (r_ref - r_cnt);
  assign w_match   = (w_diff <= TOL_C);
  assign w_sat     = (r_cnt == CNT_MAX) && !w_rise;
  assign state_dbg = r_state;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ref      <= '0;
      r_mcnt     <= '0;
      rise_p     <= 1'b0;
      fall_p     <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      rise_p     <= w_rise;
      fall_p     <= w_fall;
      period_vld <= 1'b0;
      // locked follows entry into LOCKED one cycle later; drops below override it.
      if (r_state == ST_LOCKED) begin
        locked <= 1'b1;
      end
      if (w_rise) begin
        r_cnt <= CNT_ONE;
        if (r_state != ST_IDLE) begin
          period     <= r_cnt;
          period_vld <= 1'b1;
        end
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_MEAS;
            timeout <= 1'b0;
          end
          ST_MEAS: begin
            r_ref   <= r_cnt;
            r_mcnt  <= '0;
            r_state <= ST_TRACK;
          end
          ST_TRACK: begin
            if (w_match) begin
              if (r_mcnt == MC_LAST) begin
                r_state <= ST_LOCKED;
              end else begin
                r_mcnt <= r_mcnt + MC_ONE;
              end
            end else begin
              r_ref  <= r_cnt;
              r_mcnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (!w_match) begin
              locked  <= 1'b0;
              r_ref   <= r_cnt;
              r_mcnt  <= '0;
              r_state <= ST_TRACK;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_sat) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
        r_mcnt  <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] r_hcnt;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_hcnt    <= '0;
      high_time <= '0;
      high_vld  <= 1'b0;
    end else begin
      high_vld <= 1'b0;
      if (w_rise) begin
        r_hcnt <= CNT_ONE;
      end else if (r_hcnt != CNT_MAX) begin
        r_hcnt <= r_hcnt + CNT_ONE;
      end
      if (w_fall) begin
        high_time <= r_hcnt;
        high_vld  <= (r_state != ST_IDLE);
      end
    end
  end
`endif

endmodule

// File: tb/tb_clk_edge_rx.sv
// Bench for clk_edge_rx with CNT_W=8, TOL=1, LOCK_N=4; sig_in driven on clk_in negedges.
// Expected periods/latencies are queued by the driver and checked by a negedge monitor.
module tb_clk_edge_rx;

  localparam int CNT_W  = 8;
  localparam int TOL    = 1;
  localparam int LOCK_N = 4;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             sig_in = 1'b0;
  logic             rise_p;
  logic             fall_p;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             timeout;
  logic [1:0]       state_dbg;
`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] high_time;
  logic             high_vld;
`endif

  clk_edge_rx #(.CNT_W(CNT_W), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (sig_in),
    .rise_p     (rise_p),
    .fall_p     (fall_p),
    .period     (period),
    .period_vld (period_vld),
`ifdef DUTY_MEAS_EN
    .high_time  (high_time),
    .high_vld   (high_vld),
`endif
    .locked     (locked),
    .timeout    (timeout),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // scoreboard state
  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] high_q[$];
  int               rise_exp_q[$];
  int               fall_exp_q[$];
  int               rise_cyc[64];
  int               rise_idx      = 0;
  int               lock_up_cyc   = -1;
  int               lock_down_cyc = -1;
  int               rel_cyc       = 0;
  logic             prev_rise     = 1'b0;
  logic             prev_fall     = 1'b0;
  logic             prev_locked   = 1'b0;
  int               m_rises       = 0;
  int               m_prev_len    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk_in) begin
    if (!rst) begin
      if (rise_p) begin
        if (rise_exp_q.size() == 0) chk("rise_unexpected", 1, 0);
        else chk("rise_latency", cyc, rise_exp_q.pop_front());
        chk("rise_width", int'(prev_rise), 0);
        if (rise_idx < 63) rise_idx++;
        rise_cyc[rise_idx] = cyc;
      end
      if (fall_p) begin
        if (fall_exp_q.size() == 0) chk("fall_unexpected", 1, 0);
        else chk("fall_latency", cyc, fall_exp_q.pop_front());
        chk("fall_width", int'(prev_fall), 0);
      end
      if (period_vld) begin
        chk("vld_with_rise", int'(rise_p), 1);
        if (exp_q.size() == 0) chk("period_vld_unexpected", 1, 0);
        else chk("period", int'(period), int'(exp_q.pop_front()));
      end
`ifdef DUTY_MEAS_EN
      if (high_vld) begin
        chk("high_vld_with_fall", int'(fall_p), 1);
        if (high_q.size() == 0) chk("high_vld_unexpected", 1, 0);
        else chk("high_time", int'(high_time), int'(high_q.pop_front()));
      end
`endif
      if (locked && !prev_locked) lock_up_cyc = cyc;
      if (!locked && prev_locked) lock_down_cyc = cyc;
    end
    prev_rise   = rise_p;
    prev_fall   = fall_p;
    prev_locked = locked;
  end

  // driver tasks: one full sig_in period, hi cycles high then lo cycles low
  task automatic drive(input int hi, input int lo);
    sig_in = 1'b1;
    if (m_rises >= 1) exp_q.push_back(CNT_W'(m_prev_len));
    m_rises++;
    m_prev_len = hi + lo;
    rise_exp_q.push_back(cyc + 3);
    repeat (hi) @(negedge clk_in);
    sig_in = 1'b0;
    fall_exp_q.push_back(cyc + 3);
`ifdef DUTY_MEAS_EN
    high_q.push_back(CNT_W'(hi));
`endif
    repeat (lo) @(negedge clk_in);
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    chk("rst_rise_p", int'(rise_p), 0);
    chk("rst_fall_p", int'(fall_p), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_period_vld", int'(period_vld), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_state", int'(state_dbg), 0);
    @(negedge clk_in);
    rst      = 1'b0;
    rel_cyc  = cyc;
    m_rises  = 0;
    rise_idx = 0;
    #2;
  endtask

  task automatic wait_timeout(input string name, input int exp_cyc);
    for (int i = 0; i < 400 && !timeout; i++) @(negedge clk_in);
    chk(name, cyc, exp_cyc);
    m_rises = 0;
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk_in);
    pulse_reset();

    // idle input: counter runs 0..255, saturation seen one edge later
    wait_timeout("timeout_idle", rel_cyc + 256);
    chk("locked_idle", int'(locked), 0);
    repeat (20) @(negedge clk_in);
    #2;
    chk("timeout_sticky", int'(timeout), 1);

    // period 4: lock one cycle after the 6th rise_p
    drive(2, 2);
    chk("timeout_cleared", int'(timeout), 0);
    repeat (5) drive(2, 2);
    chk("lock_up_p4", lock_up_cyc, rise_cyc[6] + 1);
    chk("locked_p4", int'(locked), 1);

    // one period of 7 drops lock with that rise_p, five in a row relock
    drive(2, 5);
    drive(2, 5);
    chk("lock_down_p7", lock_down_cyc, rise_cyc[8]);
    chk("unlocked_p7", int'(locked), 0);
    repeat (4) drive(2, 5);
    chk("lock_up_p7", lock_up_cyc, rise_cyc[12] + 1);
    chk("locked_p7", int'(locked), 1);

    // reset while locked, then tolerance sequence 4,5,4,3,4,5 then 6
    pulse_reset();
    drive(2, 2);
    chk("no_lock_after_rst", int'(locked), 0);
    drive(2, 3);
    drive(2, 2);
    drive(2, 1);
    drive(2, 2);
    drive(2, 3);
    chk("lock_up_tol", lock_up_cyc, rise_cyc[6] + 1);
    chk("locked_tol", int'(locked), 1);
    drive(3, 3);
    chk("locked_tol_5", int'(locked), 1);
    drive(2, 2);
    chk("lock_down_tol", lock_down_cyc, rise_cyc[8]);
    chk("unlocked_tol_6", int'(locked), 0);

    // duty 3 high / 5 low, period 8
    repeat (3) drive(3, 5);

    // stop toggling: timeout 255 cycles after the last rise_p
    wait_timeout("timeout_after_rise", rise_cyc[rise_idx] + 255);
    chk("locked_timeout", int'(locked), 0);

    // period of exactly 255: rise and saturation coincide, rise wins
    drive(100, 155);
    chk("timeout_clear2", int'(timeout), 0);
    drive(2, 2);
    chk("timeout_rise_wins", int'(timeout), 0);

    repeat (8) @(negedge clk_in);
    #2;
    chk("exp_q_empty", exp_q.size(), 0);
    chk("rise_q_empty", rise_exp_q.size(), 0);
    chk("fall_q_empty", fall_exp_q.size(), 0);
`ifdef DUTY_MEAS_EN
    chk("high_q_empty", high_q.size(), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
